// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and default sizing for the multiplier-sharing arbiter.
//   arb_state_t : FSM encoding (IDLE, ISSUE, WAIT, RESP)
//   DEF_*       : default requester count, operand width and watchdog limit
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int unsigned DEF_N_REQ   = 4;
  localparam int unsigned DEF_WIDTH   = 4;
  localparam int unsigned DEF_TIMEOUT = 64;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Bundle between the arbiter, its requesters and the shared multiplier.
//   Requester side : req, a_in, b_in -> gnt, rsp_valid, rsp_prod, rsp_err, busy
//   Multiplier side: mul_valid, mul_a, mul_b -> mul_prod, mul_done
//   slave  : arbiter view
//   master : environment view (requesters + multiplier wrapper)
interface mult_share_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_in;
  logic [N_REQ*WIDTH-1:0] b_in;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]     rsp_prod;
  logic                   rsp_err;
  logic                   mul_valid;
  logic [WIDTH-1:0]       mul_a;
  logic [WIDTH-1:0]       mul_b;
  logic [2*WIDTH-1:0]     mul_prod;
  logic                   mul_done;
  logic                   busy;

  modport slave (
    input  req, a_in, b_in, mul_prod, mul_done,
    output gnt, rsp_valid, rsp_prod, rsp_err, mul_valid, mul_a, mul_b, busy
  );

  modport master (
    output req, a_in, b_in, mul_prod, mul_done,
    input  gnt, rsp_valid, rsp_prod, rsp_err, mul_valid, mul_a, mul_b, busy
  );

endinterface

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i  : request vector
//   last_i : index of the most recently served requester
//   gnt_o  : one-hot winner, searching upward from last_i+1 (wrapping)
//   idx_o  : binary index of the winner
//   any_o  : at least one request present
module rr_pick
  import mult_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = DEF_N_REQ,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // k runs 1..N_REQ so the last-served requester is considered last.
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand     = (32'(last_i) + k) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!any_o && req_i[cand_idx]) begin
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
        any_o           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin scheduler sharing one sequential multiplier among N_REQ
// requesters. Latches the winner's operands, pulses the multiplier start,
// waits for DONE (guarded by a watchdog) and returns the product with a
// one-cycle one-hot response strobe.
//   clk, rst : clock, synchronous active-high reset
//   bus      : requester and multiplier signals (slave view)
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = DEF_N_REQ,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input logic                 clk,
  input logic                 rst,
  mult_share_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned WD_W  = $clog2(TIMEOUT);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               err_q, err_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic               mul_valid_q, mul_valid_d;
  logic               busy_q, busy_d;

  logic [N_REQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [WIDTH-1:0]   a_arr [N_REQ];
  logic [WIDTH-1:0]   b_arr [N_REQ];
  logic [N_REQ-1:0]   owner_oh;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i  (bus.req),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      a_arr[i] = bus.a_in[i*WIDTH +: WIDTH];
      b_arr[i] = bus.b_in[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    wd_d     = wd_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    prod_d   = prod_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = ISSUE;
          idx_d   = pick_idx;
          mul_a_d = a_arr[pick_idx];
          mul_b_d = b_arr[pick_idx];
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.mul_done) begin
          prod_d  = bus.mul_prod;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP: begin
        last_d  = idx_q;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so that every output is a flop
  // that is valid in the same cycle as the state it belongs to.
  always_comb begin
    owner_oh         = '0;
    owner_oh[idx_d]  = 1'b1;
    mul_valid_d      = (state_d == ISSUE);
    busy_d           = (state_d != IDLE);
    gnt_d            = (state_d == IDLE) ? '0 : owner_oh;
    rsp_valid_d      = (state_d == RESP) ? owner_oh : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      last_q      <= IDX_W'(N_REQ - 1);
      wd_q        <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      prod_q      <= '0;
      err_q       <= 1'b0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      mul_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      wd_q        <= wd_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      prod_q      <= prod_d;
      err_q       <= err_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      mul_valid_q <= mul_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_prod  = prod_q;
  assign bus.rsp_err   = err_q;
  assign bus.mul_valid = mul_valid_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.busy      = busy_q;

endmodule
